// File: rtl/data_memory_ls.sv
// data_memory_ls: RV32I byte/half/word load-store data memory with a valid/ready request and a registered response
// Ports: clk, rst_n (async, active-low); request req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/req_wdata;
//   response rsp_valid (one-cycle pulse), rsp_rdata (extended load data, 0 for stores/errors), rsp_err.
// Build option MEM_CLEAR_INIT_EN: after reset, sweep zeros into every word (DEPTH cycles) before accepting requests.
module data_memory_ls #(
  parameter int DEPTH = 64,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);
  localparam int IW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic ready, accept, err, wr;
  logic [IW-1:0] idx;
  logic [3:0] lanes;
  logic [31:0] wword, word, shifted, ld;
  assign req_ready = ready;
  assign accept = req_valid & ready;
  assign idx = req_addr[IW+1:2];
  // any set bit above the word index means the word number is >= DEPTH
  assign err = (req_size == 2'd3) | ((req_size == 2'd1) & req_addr[0]) |
               ((req_size == 2'd2) & (|req_addr[1:0])) | (|req_addr[AW-1:IW+2]);
  assign wr = accept & req_we & ~err;
  assign lanes = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                 req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // replicate store data so every enabled lane sees its right-aligned bytes
  assign wword = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                 req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  assign word = mem[idx];
  assign shifted = word >> {req_addr[1:0], 3'b000};
  assign ld = req_size == 2'd0 ? {{24{~req_unsigned & shifted[7]}}, shifted[7:0]} :
              req_size == 2'd1 ? {{16{~req_unsigned & shifted[15]}}, shifted[15:0]} : word;
`ifdef MEM_CLEAR_INIT_EN
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] clr_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH - 1)) state <= RUN;
    end
  assign ready = state == RUN;
  always_ff @(posedge clk)
    if (state == INIT) mem[clr_cnt] <= '0;
    else for (int b = 0; b < 4; b++) if (wr & lanes[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ready <= 1'b0;
    else ready <= 1'b1;
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++) if (wr & lanes[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= err;
        rsp_rdata <= (err | req_we) ? '0 : ld;
      end
    end
endmodule

// File: tb/tb_data_memory_ls.sv
// tb_data_memory_ls: directed load/store checks against a byte-array model of the data memory
module tb_data_memory_ls;
  localparam int DEPTH = 64;
`ifdef MEM_CLEAR_INIT_EN
  localparam int LAT = DEPTH;
  localparam bit CLR = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  data_memory_ls #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  logic [7:0] mb [DEPTH*4];
  bit kn [DEPTH*4];
  int cnt = 0;
  logic e_valid = 1'b0, e_err = 1'b0, e_chk = 1'b1;
  logic [31:0] e_rdata = '0;
  wire exp_ready = rst_n && cnt >= LAT;
  function automatic logic m_err(input logic [31:0] a, input logic [1:0] s);
    return s == 2'd3 || (a % (32'd1 << s)) != 0 || (a >> 2) >= DEPTH;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v = '0;
    int n = 1 << s;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
    if (!u && n < 4 && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction
  function automatic logic m_known(input logic [31:0] a, input logic [1:0] s);
    logic k = 1'b1;
    for (int i = 0; i < (1 << s); i++) k = k & kn[a+i];
    return k;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0;
      e_valid <= 1'b0;
      e_rdata <= '0;
      e_err <= 1'b0;
      e_chk <= 1'b1;
      for (int i = 0; i < DEPTH * 4; i++) begin
        mb[i] <= CLR ? 8'h00 : 8'hxx;
        kn[i] <= CLR;
      end
    end else begin
      if (cnt < LAT) cnt <= cnt + 1;
      e_valid <= 1'b0;
      if (cnt >= LAT && req_valid) begin
        e_valid <= 1'b1;
        e_err <= m_err(req_addr, req_size);
        e_rdata <= (m_err(req_addr, req_size) || req_we) ? 32'h0 : m_load(req_addr, req_size, req_unsigned);
        e_chk <= (m_err(req_addr, req_size) || req_we) ? 1'b1 : m_known(req_addr, req_size);
        if (req_we && !m_err(req_addr, req_size))
          for (int i = 0; i < (1 << req_size); i++) begin
            mb[req_addr+i] <= req_wdata[8*i +: 8];
            kn[req_addr+i] <= 1'b1;
          end
      end
    end
  always @(negedge clk) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
    if (e_chk) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
    end
  end
  task automatic xfer(input logic we, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input string n);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_size = s;
    req_unsigned = u;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({n, ".valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({n, ".rdata"}, rsp_rdata, er);
    chk({n, ".err"}, {31'b0, rsp_err}, {31'b0, ee});
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string n);
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    chk(n, k, LAT);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_ready("init_len");
`ifdef MEM_CLEAR_INIT_EN
    xfer(0, 32'h00, 2'd2, 0, 0, 32'h0, 0, "lw_cleared");
`endif
    xfer(1, 32'h00, 2'd2, 0, 32'h0, 32'h0, 0, "sw_00");
    xfer(1, 32'h04, 2'd2, 0, 32'h0, 32'h0, 0, "sw_04");
    xfer(1, 32'h10, 2'd2, 0, 32'h808182F3, 32'h0, 0, "sw_10");
    xfer(0, 32'h10, 2'd0, 0, 0, 32'hFFFFFFF3, 0, "lb_10");
    xfer(0, 32'h13, 2'd0, 1, 0, 32'h00000080, 0, "lbu_13");
    xfer(0, 32'h12, 2'd1, 0, 0, 32'hFFFF8081, 0, "lh_12");
    xfer(0, 32'h10, 2'd1, 1, 0, 32'h000082F3, 0, "lhu_10");
    xfer(1, 32'h20, 2'd2, 0, 32'h11223344, 32'h0, 0, "sw_20");
    xfer(1, 32'h21, 2'd0, 0, 32'h55AA, 32'h0, 0, "sb_21");
    xfer(0, 32'h20, 2'd2, 0, 0, 32'h1122AA44, 0, "lw_20a");
    xfer(1, 32'h22, 2'd1, 0, 32'h1234BEEF, 32'h0, 0, "sh_22");
    xfer(0, 32'h20, 2'd2, 0, 0, 32'hBEEFAA44, 0, "lw_20b");
    xfer(0, 32'h05, 2'd2, 0, 0, 32'h0, 1, "lw_05_mis");
    xfer(1, 32'h07, 2'd1, 0, 32'hFFFF, 32'h0, 1, "sh_07_mis");
    xfer(1, 32'h10, 2'd3, 0, 32'h12345678, 32'h0, 1, "size11");
    xfer(1, 32'h100, 2'd2, 0, 32'hCAFEF00D, 32'h0, 1, "sw_100_oob");
    xfer(0, 32'h04, 2'd2, 0, 0, 32'h0, 0, "lw_04_keep");
    xfer(0, 32'h10, 2'd2, 0, 0, 32'h808182F3, 0, "lw_10_keep");
    xfer(0, 32'h00, 2'd2, 0, 0, 32'h0, 0, "lw_00_keep");
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h30;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_we = 1'b0;
    @(negedge clk);
    chk("b2b.st_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b.st_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.ld_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b.ld_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b.idle", {31'b0, rsp_valid}, 32'd0);
    chk("b2b.hold", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1 req_valid = 1'b1;
    req_addr = 32'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst.pre_valid", {31'b0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid_drop", {31'b0, rsp_valid}, 32'd0);
    chk("rst.ready_drop", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reinit_len");
`ifdef MEM_CLEAR_INIT_EN
    xfer(0, 32'h30, 2'd2, 0, 0, 32'h0, 0, "lw_30_cleared");
`else
    xfer(1, 32'h30, 2'd2, 0, 32'h0BADF00D, 32'h0, 0, "sw_30_again");
    xfer(0, 32'h30, 2'd2, 0, 0, 32'h0BADF00D, 0, "lw_30_again");
`endif
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
